// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
package truth_table_sequencer_pkg;

    localparam int NUM_FUNCS = 5;
    localparam int TABLE_W   = 8;

    localparam logic [2:0] SEL_S1 = 3'd0;
    localparam logic [2:0] SEL_S2 = 3'd1;
    localparam logic [2:0] SEL_S3 = 3'd2;
    localparam logic [2:0] SEL_S4 = 3'd3;
    localparam logic [2:0] SEL_S5 = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    function automatic logic sel_valid(input logic [2:0] s);
        return s < 3'(NUM_FUNCS);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_maxterm_eval.sv
// Combinational evaluator for the five product-of-sums functions of x,y,z.
module maxterm_eval (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic s5
);

    assign s1 = (~y | ~z) & (~x | ~z);
    assign s2 = (~y |  z) & (~x |  z);
    assign s3 = (~y |  z) & ( y | ~z);
    assign s4 = ( x | ~y) & (~x | ~y);
    assign s5 = ( x | ~y) & (~x |  y);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps {x,y,z} through 0..7 and captures the selected function's truth table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         sel,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         xyz,
    output logic [TABLE_W-1:0] table_out,
    output logic [3:0]         ones
);

    state_t     state;
    logic [2:0] idx;
    logic [2:0] sel_q;
    logic       s1, s2, s3, s4, s5;
    logic       f;

    maxterm_eval u_eval (
        .x  (idx[2]),
        .y  (idx[1]),
        .z  (idx[0]),
        .s1 (s1),
        .s2 (s2),
        .s3 (s3),
        .s4 (s4),
        .s5 (s5)
    );

    always_comb begin
        f = 1'b0;
        case (sel_q)
            SEL_S1:  f = s1;
            SEL_S2:  f = s2;
            SEL_S3:  f = s3;
            SEL_S4:  f = s4;
            SEL_S5:  f = s5;
            default: f = 1'b0;
        endcase
    end

    // idx is kept at 0 outside SWEEP, so it doubles as the xyz output
    assign xyz = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            sel_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            table_out <= '0;
            ones      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sel_valid(sel)) begin
                            state     <= SWEEP;
                            busy      <= 1'b1;
                            idx       <= '0;
                            sel_q     <= sel;
                            table_out <= '0;
                            ones      <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        idx       <= '0;
                        table_out <= '0;
                        ones      <= '0;
                    end else begin
                        table_out[idx] <= f;
                        ones           <= ones + {3'b000, f};
                        if (idx == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: random sweeps, invalid selects, aborts and async reset.
module tb_truth_table_sequencer;

    typedef struct packed {
        logic [7:0] tbl;
        logic [3:0] ones;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] sel;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] xyz;
    logic [7:0] table_out;
    logic [3:0] ones;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur;

    truth_table_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .xyz       (xyz),
        .table_out (table_out),
        .ones      (ones)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: evaluate each function straight from its maxterm form
    function automatic exp_t ref_model(input logic [2:0] s);
        exp_t r;
        bit   x, y, z, b;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            x = bit'((i >> 2) & 1);
            y = bit'((i >> 1) & 1);
            z = bit'(i & 1);
            case (s)
                3'd0:    b = (!y || !z) && (!x || !z);
                3'd1:    b = (!y ||  z) && (!x ||  z);
                3'd2:    b = (!y ||  z) && ( y || !z);
                3'd3:    b = ( x || !y) && (!x || !y);
                default: b = ( x || !y) && (!x ||  y);
            endcase
            r.tbl[i] = b;
            r.ones   = r.ones + 4'(b);
        end
        return r;
    endfunction

    function automatic exp_t dir_exp(input logic [2:0] s);
        case (s)
            3'd0:    return {8'h57, 4'd5};
            3'd1:    return {8'hAB, 4'd5};
            3'd2:    return {8'h99, 4'd4};
            3'd3:    return {8'h33, 4'd4};
            default: return {8'hC3, 4'd4};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding sweep
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_table", 32'(table_out), 32'(e.tbl));
                check("sb_ones", 32'(ones), 32'(e.ones));
            end
        end
    end

    task automatic run_sweep(input logic [2:0] s, input bit directed,
                             input int abort_at);
        exp_t e;
        e     = directed ? dir_exp(s) : ref_model(s);
        start = 1'b1;
        sel   = s;
        abort = 1'($urandom % 2);
        exp_q.push_back(e);
        @(negedge clk);
        check("cleared_table", 32'(table_out), 32'd0);
        check("cleared_ones", 32'(ones), 32'd0);
        for (int j = 0; j < 8; j++) begin
            check("busy_sweep", 32'(busy), 32'd1);
            check("xyz_step", 32'(xyz), 32'(j));
            check("done_early", 32'(done), 32'd0);
            if (j == abort_at) begin
                start = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_table", 32'(table_out), 32'd0);
                check("abort_ones", 32'(ones), 32'd0);
                check("abort_xyz", 32'(xyz), 32'd0);
                void'(exp_q.pop_back());
                cur = '0;
                return;
            end
            start = 1'($urandom % 2);
            sel   = 3'($urandom);
            abort = 1'b0;
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("xyz_done", 32'(xyz), 32'd0);
        cur   = e;
        start = 1'($urandom % 2);
        sel   = 3'($urandom);
        abort = 1'($urandom % 2);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("hold_table", 32'(table_out), 32'(cur.tbl));
        check("hold_ones", 32'(ones), 32'(cur.ones));
    endtask

    task automatic run_invalid(input logic [2:0] s);
        start = 1'b1;
        sel   = s;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_table", 32'(table_out), 32'(cur.tbl));
        check("err_ones", 32'(ones), 32'(cur.ones));
        @(negedge clk);
        check("err_one_cycle", 32'(err), 32'd0);
    endtask

    task automatic idle_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_table", 32'(table_out), 32'(cur.tbl));
    endtask

    task automatic reset_mid_sweep(input int cycles);
        start = 1'b1;
        sel   = 3'($urandom_range(4, 0));
        @(negedge clk);
        start = 1'b0;
        repeat (cycles) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_xyz", 32'(xyz), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_ones", 32'(ones), 32'd0);
        cur = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int op;
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 3'd0;
        abort = 1'b0;
        cur   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_xyz", 32'(xyz), 32'd0);
        check("reset_table", 32'(table_out), 32'd0);
        check("reset_ones", 32'(ones), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 5; s++) run_sweep(3'(s), 1'b1, -1);
        run_invalid(3'd6);
        idle_abort();
        run_sweep(3'd2, 1'b1, 4);
        run_sweep(3'd2, 1'b1, -1);
        run_sweep(3'd4, 1'b1, 7);
        reset_mid_sweep(3);
        run_sweep(3'd0, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom % 5);
            case (op)
                0, 1: run_sweep(3'($urandom_range(4, 0)), 1'b0, -1);
                2:    run_invalid(3'($urandom_range(7, 5)));
                3:    run_sweep(3'($urandom_range(4, 0)), 1'b0,
                                int'($urandom_range(7, 0)));
                default: idle_abort();
            endcase
        end
        reset_mid_sweep(int'($urandom_range(6, 1)));
        run_sweep(3'($urandom_range(4, 0)), 1'b0, -1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
